// File: rtl/alu_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct3 op encodings, FSM state encoding and op-class helpers.
package alu_muldiv_iter_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is interpreted as signed.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as signed.
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_datapath.sv
// Iterative datapath: 2*XLEN accumulator plus operand register.
// Multiply: shift-add, accumulator = {partial product, multiplier}.
// Divide: restoring, accumulator = {partial remainder, dividend/quotient}.
// One result bit per step; acc_next exposes the value the next edge stores.
module alu_muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_in,
  input  logic [XLEN-1:0]   b_in,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     trial;

  // Load operands or perform one multiply/divide iteration.
  always_comb begin
    acc_d   = acc_q;
    opb_d   = opb_q;
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Partial remainder shifted left with the next dividend bit; needs XLEN+1 bits.
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    trial   = rem_sh - {1'b0, opb_q};
    if (load) begin
      acc_d = {{XLEN{1'b0}}, a_in};
      opb_d = b_in;
    end else if (step) begin
      if (is_div) begin
        acc_d = {(trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0]),
                 acc_q[XLEN-2:0], ~trial[XLEN]};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  assign acc_next = acc_d;

  // Accumulator and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready on both sides.
// Optional build macro: MDU_FAST_MUL_EN -- multiplies use a single-cycle
// combinational multiplier (IDLE->DONE on accept); division stays iterative.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds data stable while valid is high and ready is low.
module alu_muldiv_iter
  import alu_muldiv_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = $clog2(XLEN);

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              dp_load, dp_step, dp_is_div;
  logic              accept, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc_next;

  // Sign-fix the unsigned magnitude result and pick the requested part.
  function automatic logic [XLEN-1:0] finish_result(input logic [2:0] f_op,
                                                    input logic f_sa, input logic f_sb,
                                                    input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = (f_sa ^ f_sb) ? -acc : acc;
    quo  = (f_sa ^ f_sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = f_sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f_op)
      OP_MUL:                       return prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              return quo;
      default:                      return rem;
    endcase
  endfunction

  // Operand conditioning and special-case detection on the request inputs.
  always_comb begin
    sa       = is_signed_a(op) & in1[XLEN-1];
    sb       = is_signed_b(op) & in2[XLEN-1];
    mag_a    = sa ? -in1 : in1;
    mag_b    = sb ? -in2 : in2;
    div_zero = is_div(op) && (in2 == '0);
    div_ovf  = is_div(op) && !op[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b;
  logic [2*XLEN-1:0]        fast_p;
  logic [XLEN-1:0]          fast_res;
  // Single-cycle signed product over sign/zero-extended operands.
  always_comb begin
    fast_a   = {{XLEN{sa}}, in1};
    fast_b   = {{XLEN{sb}}, in2};
    fast_p   = fast_a * fast_b;
    fast_res = (op == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`endif

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // FSM next-state, operand capture and result register update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_is_div = is_div(op_q);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = op;
          sign_a_d  = sa;
          sign_b_d  = sb;
          dp_is_div = is_div(op);
          if (div_zero) begin
            res_d   = op[1] ? in1 : '1;
            state_d = ST_DONE;
          end else if (div_ovf) begin
            res_d   = op[1] ? '0 : in1;
            state_d = ST_DONE;
`ifdef MDU_FAST_MUL_EN
          end else if (!is_div(op)) begin
            res_d   = fast_res;
            state_d = ST_DONE;
`endif
          end else begin
            dp_load = 1'b1;
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        dp_step = 1'b1;
        if (cnt_q == '0) begin
          res_d   = finish_result(op_q, sign_a_q, sign_b_q, acc_next);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A kill leaves the last result in place and returns to IDLE.
    if (flush) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  alu_muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .step     (dp_step),
    .is_div   (dp_is_div),
    .a_in     (mag_a),
    .b_in     (mag_b),
    .acc_next (acc_next)
  );

  assign out_valid  = (state_q == ST_DONE);
  assign out_result = res_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Bench for alu_muldiv_iter (XLEN=32): directed and random requests, a
// queue-based scoreboard fed by the driver and drained by a monitor.
module tb_alu_muldiv_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]      op;
  logic [XLEN-1:0] in1, in2, out_result;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit seen   = 0;
  bit rand_done;

  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  int              acc_cyc_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  alu_muldiv_iter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mdu(input logic [2:0] f_op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint     sa_v = longint'($signed(a));
    longint     sb_v = longint'($signed(b));
    longint     ua   = longint'({32'b0, a});
    longint     ub   = longint'({32'b0, b});
    logic [63:0] p;
    bit         ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f_op)
      3'd0: begin p = sa_v * sb_v; return p[31:0];  end
      3'd1: begin p = sa_v * sb_v; return p[63:32]; end
      3'd2: begin p = sa_v * ub;   return p[63:32]; end
      3'd3: begin p = ua * ub;     return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa_v / sb_v);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(sa_v % sb_v);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f_op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f_op[2] && (b == 0)) return 1;
    if ((f_op == 3'd4 || f_op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!f_op[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_out);
    int budget = 0;
    while (!in_ready && budget < 200) begin
      step();
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready still 0 after %0d cycles, expected 1", budget);
      return;
    end
    in_valid = 1'b1;
    op       = o;
    in1      = a;
    in2      = b;
    if (expect_out) begin
      exp_q.push_back(ref_mdu(o, a, b));
      lat_q.push_back(ref_lat(o, a, b));
      acc_cyc_q.push_back(cyc + 1);
    end
    step();
    in_valid = 1'b0;
    op       = 3'($urandom_range(0, 7));
    in1      = $urandom;
    in2      = $urandom;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((exp_q.size() != 0 || !in_ready) && budget < 500) begin
      step();
      budget++;
    end
    if (exp_q.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, in_ready=%0b", exp_q.size(), in_ready);
      exp_q.delete();
      lat_q.delete();
      acc_cyc_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid=1 result=%0h, no result expected (cycle %0d)",
                 out_result, cyc);
      end else begin
        if (!seen) begin
          seen = 1;
          check("latency", 64'(cyc + 1 - acc_cyc_q[0]), 64'(lat_q[0]));
        end
        check("result", out_result, exp_q[0]);
        if (!out_ready) check("in_ready_while_held", in_ready, 1'b0);
        else begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_cyc_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; in1 = '0; in2 = '0; rand_done = 0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_result", out_result, 32'd0);
    check("rst_state", dbg_state, 2'd0);
    repeat (3) step();
    rst = 1'b0;
    step();

    // Directed operations from the block's test plan.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1);
    issue(3'd3, 32'h8000_0000, 32'h8000_0000, 1);
    issue(3'd2, 32'h8000_0000, 32'h8000_0000, 1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'd5, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'd5, 32'd10, 32'd0, 1);
    issue(3'd7, 32'd10, 32'd0, 1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_drain();

    // Backpressure: hold the result, then release with a competing request.
    out_ready = 1'b0;
    issue(3'd1, $urandom, $urandom, 1);
    budget = 0;
    while (!out_valid && budget < 100) begin step(); budget++; end
    check("bp_out_valid", out_valid, 1'b1);
    repeat (5) step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 3'd5;
    in2       = 32'd0;
    step();
    in_valid = 1'b0;
    check("bp_in_ready_after", in_ready, 1'b1);
    check("bp_no_reaccept", busy, 1'b0);
    wait_drain();

    // Flush mid-divide: no result may appear.
    issue(3'd4, $urandom, 32'd3, 0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    repeat (40) step();
    // Flush beats a same-cycle request.
    in_valid = 1'b1; flush = 1'b1; op = 3'd5; in1 = 32'd5; in2 = 32'd0;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept_busy", busy, 1'b0);
    check("flush_vs_accept_valid", out_valid, 1'b0);

    // Asynchronous reset mid-calculation.
    issue(3'd0, 32'd12345, 32'd678, 0);
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_result", out_result, 32'd0);
    step();
    rst = 1'b0;
    step();
    issue(3'd5, 32'd1000, 32'd7, 1);
    wait_drain();

    // Random operations with random output backpressure.
    fork
      begin
        for (int i = 0; i < 60; i++) issue(3'($urandom_range(0, 7)), pick(), pick(), 1);
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
